// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake states, dcache address
// fields and the memory arbiter sequencing states.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int DTAG_W     = 26;
  localparam int DIDX_W     = 3;
  localparam int DBLK_W     = 1;
  localparam int DBYT_W     = 2;
  localparam int DBLK_WORDS = 2**DBLK_W;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic [DBLK_W-1:0] blkoff;
    logic [DBYT_W-1:0] bytoff;
  } dcachef_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DRD0   = 3'd2,
    DRD1   = 3'd3,
    DWR0   = 3'd4,
    DWR1   = 3'd5
  } arbstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between icache word fetches and dcache two-word
// block reads/writebacks, with data priority and a bounded icache starvation guard.
//
// state  | meaning
// IDLE   | no strobes; arbitrate between pending requests
// IFETCH | icache word read
// DRD0/1 | dcache block read, word 0 / word 1
// DWR0/1 | dcache block writeback, word 0 / word 1
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        iREN,
  input  word_t                       iaddr,
  output logic                        iwait,
  output word_t                       iload,
  input  logic                        dREN,
  input  logic                        dWEN,
  input  word_t                       daddr,
  input  word_t [DBLK_WORDS-1:0]      dstore,
  output logic                        dwait,
  output word_t [DBLK_WORDS-1:0]      dload,
  output logic                        ramREN,
  output logic                        ramWEN,
  output word_t                       ramaddr,
  output word_t                       ramstore,
  input  word_t                       ramload,
  input  ramstate_t                   ramstate,
  output logic                        ramerr
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arbstate_t              r_state;
  arbstate_t              w_next;
  logic [CW-1:0]          r_starve_cnt;
  word_t                  r_wbuf;
  word_t [DBLK_WORDS-1:0] r_dload;

  dcachef_t w_dw0;
  dcachef_t w_dw1;
  logic     w_dreq;
  logic     w_drd_ok;
  logic     w_dgrant;
  logic     w_igrant;
  logic     w_wbuf_ld;
  logic     w_dload_ld;
  logic     w_unused;

  assign w_dreq   = dREN | dWEN;
  // Both strobes high means writeback, so a read is only live with dWEN low.
  assign w_drd_ok = dREN & ~dWEN;
  assign w_unused = ^iaddr[1:0];

  always_comb begin
    w_dw0        = daddr;
    w_dw0.blkoff = '0;
    w_dw0.bytoff = '0;
    w_dw1        = w_dw0;
    w_dw1.blkoff = DBLK_W'(1);
  end

  always_comb begin
    w_next     = r_state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = r_dload;
    w_dgrant   = 1'b0;
    w_igrant   = 1'b0;
    w_wbuf_ld  = 1'b0;
    w_dload_ld = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_dreq && (r_starve_cnt < STARVE_LIM || !iREN)) begin
          w_dgrant = 1'b1;
          w_next   = dWEN ? DWR0 : DRD0;
        end else if (iREN) begin
          w_igrant = 1'b1;
          w_next   = IFETCH;
        end
      end
      IFETCH: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = {iaddr[31:2], 2'b00};
          iload   = ramload;
          if (ramstate == ACCESS) begin
            iwait  = 1'b0;
            w_next = IDLE;
          end
        end
      end
      DRD0: begin
        if (!w_drd_ok) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = w_dw0;
          if (ramstate == ACCESS) begin
            w_wbuf_ld = 1'b1;
            w_next    = DRD1;
          end
        end
      end
      DRD1: begin
        if (!w_drd_ok) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = w_dw1;
          if (ramstate == ACCESS) begin
            dwait      = 1'b0;
            dload      = {ramload, r_wbuf};
            w_dload_ld = 1'b1;
            w_next     = IDLE;
          end
        end
      end
      DWR0: begin
        if (!dWEN) begin
          w_next = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = w_dw0;
          ramstore = dstore[0];
          if (ramstate == ACCESS) w_next = DWR1;
        end
      end
      DWR1: begin
        if (!dWEN) begin
          w_next = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = w_dw1;
          ramstore = dstore[1];
          if (ramstate == ACCESS) begin
            dwait  = 1'b0;
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase

    // An ERROR leaves the state untouched, so the same access goes out again.
    ramerr = (ramREN | ramWEN) & (ramstate == ERROR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_wbuf       <= '0;
      r_dload      <= '0;
    end else begin
      r_state <= w_next;
      if (w_wbuf_ld)  r_wbuf  <= ramload;
      if (w_dload_ld) r_dload <= {ramload, r_wbuf};
      if (w_igrant || (r_state == IDLE && !iREN)) begin
        r_starve_cnt <= '0;
      end else if (w_dgrant && iREN && r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small RAM model that can inject
// BUSY cycles per word and ERROR responses.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic                   CLK;
  logic                   RST;
  logic                   iREN;
  word_t                  iaddr;
  logic                   iwait;
  word_t                  iload;
  logic                   dREN;
  logic                   dWEN;
  word_t                  daddr;
  word_t [DBLK_WORDS-1:0] dstore;
  logic                   dwait;
  word_t [DBLK_WORDS-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  word_t                  ramaddr;
  word_t                  ramstore;
  word_t                  ramload;
  ramstate_t              ramstate;
  logic                   ramerr;

  int n_cmp = 0;
  int n_bad = 0;

  int    cfg_busy = 0;
  int    err_arm = 0;
  int    busy_left = 0;
  int    err_done = 0;
  word_t last_err_addr = '0;
  word_t acc_log[$];
  word_t wr_log[$];

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t rd_data(input word_t a);
    case (a)
      32'h0000_0100: return 32'h0000_AAAA;
      32'h0000_0104: return 32'h0000_BBBB;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always @* begin
    ramstate = FREE;
    ramload  = '0;
    if (ramREN || ramWEN) begin
      if (err_done < err_arm) ramstate = ERROR;
      else if (busy_left > 0) ramstate = BUSY;
      else begin
        ramstate = ACCESS;
        ramload  = rd_data(ramaddr);
      end
    end
  end

  always @(posedge CLK) begin
    if (ramREN || ramWEN) begin
      case (ramstate)
        ERROR: begin
          err_done      <= err_done + 1;
          last_err_addr <= ramaddr;
        end
        BUSY: busy_left <= busy_left - 1;
        ACCESS: begin
          busy_left <= cfg_busy;
          acc_log.push_back(ramaddr);
          if (ramWEN) wr_log.push_back(ramstore);
        end
        default: ;
      endcase
    end else begin
      busy_left <= cfg_busy;
    end
  end

  task automatic wait_done(input bit is_d, output int cyc, output int nerr);
    bit done;
    cyc  = 0;
    nerr = 0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (ramerr === 1'b1) nerr++;
      done = is_d ? (dwait === 1'b0) : (iwait === 1'b0);
    end
  endtask

  task automatic test_reset;
    n_cmp++; if ({ramREN, ramWEN, ramerr} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b expected 000", {ramREN, ramWEN, ramerr}); end
    n_cmp++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_bad++; $display("FAIL reset_ramaddr_store: got %h/%h expected 0/0", ramaddr, ramstore); end
    n_cmp++; if ({iwait, dwait} !== 2'b11) begin n_bad++; $display("FAIL reset_waits: got %b expected 11", {iwait, dwait}); end
    n_cmp++; if (iload !== 32'h0 || dload !== 64'h0) begin n_bad++; $display("FAIL reset_loads: got %h/%h expected 0/0", iload, dload); end
    n_cmp++; if (dut.r_state !== IDLE || dut.r_starve_cnt !== 3'd0 || dut.r_wbuf !== 32'h0) begin n_bad++; $display("FAIL reset_regs: got state %0d cnt %0d wbuf %h expected 0 0 0", dut.r_state, dut.r_starve_cnt, dut.r_wbuf); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_single_fetch;
    int cyc, nerr;
    @(posedge CLK); #1;
    cfg_busy = 0;
    iaddr = 32'h0000_0041;
    iREN = 1'b1;
    wait_done(1'b0, cyc, nerr);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL fetch_latency: got %0d expected 2", cyc); end
    n_cmp++; if (ramaddr !== 32'h0000_0040 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin n_bad++; $display("FAIL fetch_addr: got %h ren %b wen %b expected 00000040 1 0", ramaddr, ramREN, ramWEN); end
    n_cmp++; if (iload !== 32'hC0DE_0040) begin n_bad++; $display("FAIL fetch_data: got %h expected c0de0040", iload); end
    @(posedge CLK); #1;
    iREN = 1'b0;
  endtask

  task automatic test_block_read;
    int cyc, nerr, s;
    s = acc_log.size();
    @(posedge CLK); #1;
    cfg_busy = 0;
    daddr = 32'h0000_0104;
    dREN = 1'b1;
    wait_done(1'b1, cyc, nerr);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL blkrd_latency: got %0d expected 3", cyc); end
    n_cmp++; if (dload !== {32'h0000_BBBB, 32'h0000_AAAA}) begin n_bad++; $display("FAIL blkrd_data: got %h expected 0000bbbb0000aaaa", dload); end
    @(posedge CLK); #1;
    dREN = 1'b0;
    @(negedge CLK);
    n_cmp++; if (acc_log.size() < s + 2 || acc_log[s] !== 32'h100 || acc_log[s+1] !== 32'h104) begin n_bad++; $display("FAIL blkrd_addrs: got %0d entries expected 100,104", acc_log.size() - s); end
    n_cmp++; if (dload !== {32'h0000_BBBB, 32'h0000_AAAA} || dwait !== 1'b1) begin n_bad++; $display("FAIL blkrd_hold: got %h dwait %b expected 0000bbbb0000aaaa 1", dload, dwait); end
  endtask

  task automatic test_writeback_stall;
    int cyc, nerr, s, w;
    s = acc_log.size();
    w = wr_log.size();
    @(posedge CLK); #1;
    cfg_busy = 2;
    daddr = 32'h0000_008B;
    dstore[0] = 32'h1;
    dstore[1] = 32'h2;
    dWEN = 1'b1;
    wait_done(1'b1, cyc, nerr);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL wb_latency: got %0d expected 7", cyc); end
    n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h2) begin n_bad++; $display("FAIL wb_last_word: got wen %b ren %b data %h expected 1 0 2", ramWEN, ramREN, ramstore); end
    @(posedge CLK); #1;
    dWEN = 1'b0;
    cfg_busy = 0;
    @(negedge CLK);
    n_cmp++; if (wr_log.size() < w + 2 || wr_log[w] !== 32'h1 || wr_log[w+1] !== 32'h2) begin n_bad++; $display("FAIL wb_data_order: got %0d writes expected 1 then 2", wr_log.size() - w); end
    n_cmp++; if (acc_log.size() < s + 2 || acc_log[s] !== 32'h88 || acc_log[s+1] !== 32'h8C) begin n_bad++; $display("FAIL wb_addrs: got %0d entries expected 88,8c", acc_log.size() - s); end
  endtask

  task automatic test_contention;
    byte   grants[10];
    string exp_seq;
    int    got, cyc;
    exp_seq = "DDDDIDDDDI";
    got = 0;
    cyc = 0;
    @(posedge CLK); #1;
    cfg_busy = 0;
    iaddr = 32'h0000_0040;
    daddr = 32'h0000_0100;
    iREN = 1'b1;
    dREN = 1'b1;
    while (got < 10 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (dwait === 1'b0) begin grants[got] = "D"; got++; end
      else if (iwait === 1'b0) begin grants[got] = "I"; got++; end
    end
    @(posedge CLK); #1;
    iREN = 1'b0;
    dREN = 1'b0;
    n_cmp++; if (got !== 10) begin n_bad++; $display("FAIL starve_count: got %0d grants expected 10", got); end
    for (int i = 0; i < got; i++) begin
      n_cmp++; if (grants[i] !== exp_seq[i]) begin n_bad++; $display("FAIL starve_grant%0d: got %c expected %c", i, grants[i], exp_seq[i]); end
    end
  endtask

  task automatic test_error_retry;
    int cyc, nerr;
    @(posedge CLK); #1;
    cfg_busy = 0;
    err_arm = err_done + 1;
    iaddr = 32'h0000_0046;
    iREN = 1'b1;
    wait_done(1'b0, cyc, nerr);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL err_latency: got %0d expected 3", cyc); end
    n_cmp++; if (nerr !== 1) begin n_bad++; $display("FAIL err_pulses: got %0d expected 1", nerr); end
    n_cmp++; if (last_err_addr !== 32'h44 || ramaddr !== 32'h44) begin n_bad++; $display("FAIL err_reissue: got %h then %h expected 44 then 44", last_err_addr, ramaddr); end
    n_cmp++; if (iload !== 32'hC0DE_0044) begin n_bad++; $display("FAIL err_data: got %h expected c0de0044", iload); end
    @(posedge CLK); #1;
    iREN = 1'b0;
  endtask

  task automatic test_abort;
    @(posedge CLK); #1;
    cfg_busy = 3;
    daddr = 32'h0000_0100;
    dREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin n_bad++; $display("FAIL abort_active: got ren %b addr %h expected 1 100", ramREN, ramaddr); end
    @(posedge CLK); #1;
    dREN = 1'b0;
    @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin n_bad++; $display("FAIL abort_drop: got ren %b dwait %b expected 0 1", ramREN, dwait); end
    @(negedge CLK);
    n_cmp++; if (dload !== {32'h0000_BBBB, 32'h0000_AAAA} || ramREN !== 1'b0) begin n_bad++; $display("FAIL abort_no_complete: got %h ren %b expected 0000bbbb0000aaaa 0", dload, ramREN); end
  endtask

  task automatic test_reset_mid_drd1;
    @(posedge CLK); #1;
    cfg_busy = 3;
    iaddr = 32'h0000_0040;
    daddr = 32'h0000_0100;
    iREN = 1'b1;
    dREN = 1'b1;
    repeat (6) @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h104 || dut.r_starve_cnt !== 3'd1) begin n_bad++; $display("FAIL rst_pre: got ren %b addr %h cnt %0d expected 1 104 1", ramREN, ramaddr, dut.r_starve_cnt); end
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin n_bad++; $display("FAIL rst_mid_outputs: got ren %b addr %h dwait %b expected 0 0 1", ramREN, ramaddr, dwait); end
    n_cmp++; if (dut.r_state !== IDLE || dut.r_starve_cnt !== 3'd0 || dut.r_wbuf !== 32'h0) begin n_bad++; $display("FAIL rst_mid_regs: got state %0d cnt %0d wbuf %h expected 0 0 0", dut.r_state, dut.r_starve_cnt, dut.r_wbuf); end
    iREN = 1'b0;
    dREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    cfg_busy = 0;
  endtask

  initial begin
    RST = 1'b1;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    iaddr = '0;
    daddr = '0;
    dstore = '0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset;
    test_single_fetch;
    test_block_read;
    test_writeback_stall;
    test_contention;
    test_error_retry;
    test_abort;
    test_reset_mid_drd1;
    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
